// File: rtl/irq_priority_controller.sv
// Eight-line prioritised interrupt controller: edge capture, masking, fixed priority,
// CPU acknowledge sequencing and in-service tracking until EOI.
module irq_priority_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        data_m_addr,
    input  logic [15:0] data_m_data_in,
    input  logic [1:0]  data_m_bytesel,
    output logic [15:0] data_m_data_out,
    input  logic        data_m_wr_en,
    input  logic        data_m_access,
    output logic        data_m_ack,
    input  logic [7:0]  irq,
    output logic        intr,
    input  logic        inta,
    output logic [7:0]  vector,
    output logic        vector_valid
);

    typedef enum logic {ST_IDLE, ST_ACK} state_t;

    // Handshakes: a bus access is cs & data_m_access for one cycle and is answered by
    // data_m_ack (and read data) one cycle later; inta is a one-cycle strobe answered by
    // vector_valid one cycle later, and inta arriving during ACK is dropped.
    state_t     state;
    logic [7:0] prev_irq;
    logic [7:0] irr;
    logic [7:0] isr;
    logic [7:0] imr;
    logic [4:0] base;

    logic [7:0] rise;
    logic [7:0] pend;
    logic [2:0] p;
    logic [3:0] s;
    logic       req;
    logic       bus_wr;
    logic       bus_rd;
    logic       take;
    logic [7:0] ack_set;
    logic [7:0] eoi_clr;

    assign rise   = irq & ~prev_irq;
    assign pend   = irr & ~imr;
    assign bus_wr = cs & data_m_access & data_m_wr_en;
    assign bus_rd = cs & data_m_access & ~data_m_wr_en;

    // p: winning pending line; s: highest-priority in-service line, 8 when none
    always_comb begin
        p = 3'd0;
        s = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (pend[i]) p = 3'(i);
            if (isr[i])  s = 4'(i);
        end
    end

    assign req     = (pend != 8'h00) && ({1'b0, p} < s);
    assign take    = (state == ST_IDLE) && inta && req;
    assign ack_set = take ? (8'd1 << p) : 8'h00;

    always_comb begin
        eoi_clr = 8'h00;
        if (bus_wr && data_m_addr && data_m_bytesel[0]) begin
            if (data_m_data_in[7]) begin
                if (!s[3]) eoi_clr[s[2:0]] = 1'b1;
            end else begin
                eoi_clr[data_m_data_in[2:0]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            prev_irq        <= 8'h00;
            irr             <= 8'h00;
            isr             <= 8'h00;
            imr             <= 8'hFF;
            base            <= 5'b00001;
            intr            <= 1'b0;
            vector          <= 8'h00;
            vector_valid    <= 1'b0;
            data_m_ack      <= 1'b0;
            data_m_data_out <= 16'h0000;
        end else begin
            prev_irq <= irq;
            // a fresh edge re-arms IRR and an acknowledge set beats a same-cycle EOI
            irr <= (irr & ~ack_set) | rise;
            isr <= (isr & ~eoi_clr) | ack_set;

            if (bus_wr && !data_m_addr) begin
                if (data_m_bytesel[0]) imr  <= data_m_data_in[7:0];
                if (data_m_bytesel[1]) base <= data_m_data_in[15:11];
            end

            data_m_ack      <= cs & data_m_access;
            data_m_data_out <= bus_rd ? (data_m_addr ? {isr, irr} : {base, 3'b000, imr})
                                      : 16'h0000;

            case (state)
                ST_IDLE: begin
                    vector_valid <= 1'b0;
                    if (inta) begin
                        state        <= ST_ACK;
                        intr         <= 1'b0;
                        vector_valid <= 1'b1;
                        vector       <= {base, req ? p : 3'd7};
                    end else begin
                        intr <= req;
                    end
                end
                ST_ACK: begin
                    state        <= ST_IDLE;
                    intr         <= 1'b0;
                    vector_valid <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/irq_priority_controller.md
# irq_priority_controller

Eight-input prioritised interrupt controller for the s80x86 FPGA system. Latches rising edges on peripheral IRQ lines, applies a programmable mask, and drives a single maskable `intr` request to the CPU core. It sequences the CPU interrupt-acknowledge handshake, returns an 8-bit vector and tracks in-service levels until software issues EOI. Programmed through the same data-bus slave port style as the other system peripherals.

## Interface

Parameters:
- none; the line count is fixed at 8, with fixed priority (irq[0] highest, irq[7] lowest).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- cs  input  1  chip select from the address decoder
- data_m_addr  input  1  register select: 0 = MASK/BASE, 1 = STATUS/EOI
- data_m_data_in  input  16  write data
- data_m_bytesel  input  2  byte enables; [0] = low byte, [1] = high byte
- data_m_data_out  output  16  registered read data; 0 when not reading
- data_m_wr_en  input  1  1 = write, 0 = read
- data_m_access  input  1  bus access strobe
- data_m_ack  output  1  access acknowledge
- irq  input  8  peripheral request lines, already synchronous to clk
- intr  output  1  maskable interrupt request to the CPU
- inta  input  1  single-cycle interrupt acknowledge from the CPU
- vector  output  8  interrupt vector number
- vector_valid  output  1  one-cycle qualifier for `vector`

## Operation

Register map:
- Address 0, low byte: IMR. A 1 masks the line. Reset value 8'hFF.
- Address 0, high byte: BASE. Bits [7:3] are stored; bits [2:0] read as 0. Reset value 8'h08.
- Address 1 read: low byte = IRR, high byte = ISR.
- Address 1 write, low byte only: EOI command.
  - data[7] = 1: non-specific EOI. Clears the highest-priority set ISR bit.
  - data[7] = 0: specific EOI. Clears ISR[data[2:0]].
  - An address 1 write with bytesel[0] = 0 has no effect.
- All writes honour bytesel.

Request capture:
- prev_irq is a register of irq, reset to 0.
- A rising edge (irq[n] & ~prev_irq[n]) sets IRR[n]. This happens regardless of IMR.
- A line that is high when reset releases produces an edge on the first clock.

Priority and request:
- pend = IRR & ~IMR.
- p = lowest-index set bit of pend.
- s = lowest-index set bit of ISR, or 8 if ISR is empty.
- req = (pend != 0) & (p < s).

State machine:
- IDLE: intr <= req. When inta = 1, latch the winner and go to ACK.
  - If req is true: clear IRR[p], set ISR[p], vector <= {BASE[7:3], p}.
  - If req is false (spurious): vector <= {BASE[7:3], 3'd7]}, with no IRR or ISR change.
- ACK: vector_valid = 1 and intr = 0 for this one cycle. Go to IDLE unconditionally.
- inta while in ACK is ignored.

Boundary conditions:
- A rising edge on line n in the same cycle that inta clears IRR[n]: IRR[n] ends set (set wins) and ISR[n] is set.
- EOI in the same cycle as an inta set of the same ISR bit: the set wins.
- Changing IMR affects req on the next cycle. An already-latched ISR bit is never cleared by masking.
- reset mid-handshake returns to IDLE with all registers at their reset values.

## Timing

Reset values:
- intr = 0, vector = 0, vector_valid = 0, data_m_ack = 0, data_m_data_out = 0.
- IRR = 0, ISR = 0, IMR = 8'hFF, BASE = 8'h08, state = IDLE.

Latencies:
- data_m_ack = cs & data_m_access, registered: asserts 1 cycle after the access.
- Read data is registered with the same 1-cycle latency and is 0 whenever the cycle is not a selected read.
- Register writes take effect at the clock edge that samples the access.
- Edge to interrupt: irq[n] rising sampled at edge k gives IRR[n] = 1 after k and intr = 1 after k+1, if unmasked and of higher priority than ISR.
- Acknowledge: inta sampled at edge j gives vector and vector_valid = 1 after j, and vector_valid = 0 after j+1.
- intr is 0 during ACK. It can re-assert no earlier than 1 cycle after returning to IDLE.

## Test plan

- **Reset defaults:** after reset, read address 0 -> data_m_data_out = 16'h08FF, ack 1 cycle after access; read address 1 -> 16'h0000; intr = 0.
- **Single IRQ:** write IMR = 8'hFE, BASE = 8'h20; pulse irq[0] -> intr high 2 cycles later; pulse inta -> vector = 8'h20 with vector_valid for exactly 1 cycle, ISR = 8'h01, IRR = 0, intr low.
- **Priority and nesting:** IMR = 0; raise irq[3] and irq[5] together; first inta -> vector = BASE+3. intr stays low while ISR[3] is set (IRR[5] pending). Raise irq[1] -> intr, vector = BASE+1, ISR = 8'h0A. Non-specific EOI (8'h80) clears bit 1 only -> ISR = 8'h08.
- **Specific EOI and masking:** with ISR = 8'h08, write 8'h03 to address 1 -> ISR = 0, intr re-asserts for IRR[5]. Set IMR[5] -> intr drops next cycle while IRR[5] stays 1.
- **Spurious acknowledge:** no pending requests, pulse inta -> vector = {BASE[7:3], 3'b111}, ISR unchanged.
- **Collision and reset:** rising edge on irq[2] in the inta cycle that selects line 2 -> IRR[2] = 1 and ISR[2] = 1 afterwards. Assert reset during ACK -> vector_valid = 0 and all registers at reset values immediately.
